// File: rtl/aes128_cbc_dec_ctrl.sv
// aes128_cbc_dec_ctrl
// CBC-mode decryption controller wrapped around an external AES-128 inverse
// cipher core. It takes ciphertext blocks through a valid/ready handshake,
// starts the core, XORs the core result with the chaining value, and returns
// plaintext through a valid/ready handshake. The chaining value comes from
// iv_load for the first block and from the previous ciphertext afterwards.
//
// Optional feature: define AES128_CBC_DEC_ECB_SEL_EN to add the ecb_mode input.
// ecb_mode is sampled per block at the input handshake. A block accepted with
// ecb_mode=1 is returned as the raw core output and leaves the chain untouched.
//
// Ports
//   clk_sys      system clock, rising edge
//   rst_n        synchronous active-low reset
//   iv_load/iv   load the chaining register (IDLE only, has priority over input)
//   in_valid/in_ready/in_block     ciphertext input handshake
//   out_valid/out_ready/out_block  plaintext output handshake
//   core_en      one-cycle start pulse to the core (decipher_en)
//   core_cipher  ciphertext presented to the core
//   core_ready   core idle/done status (decipher_ready)
//   core_plain   core result
//   busy         high whenever the FSM is not in IDLE
//   blk_cnt      blocks delivered since the last iv_load (wraps)
//   ecb_mode     per-block ECB select (only with AES128_CBC_DEC_ECB_SEL_EN)
module aes128_cbc_dec_ctrl (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         iv_load,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
`ifdef AES128_CBC_DEC_ECB_SEL_EN
    input  logic         ecb_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         core_en,
    output logic [127:0] core_cipher,
    input  logic         core_ready,
    input  logic [127:0] core_plain,
    output logic         busy,
    output logic [15:0]  blk_cnt
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [BLK_W-1:0]   chain_reg;
    logic [BLK_W-1:0]   cipher_reg;
    logic               accept;
`ifdef AES128_CBC_DEC_ECB_SEL_EN
    logic               ecb_flag;
`endif

    // A new block may enter only when a pending result is absent or leaving
    // this cycle, so the single output register is never overwritten.
    assign in_ready    = rst_n && (state == IDLE) && !iv_load && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign core_cipher = cipher_reg;
    assign busy        = (state != IDLE);

    // Control FSM, datapath registers and output handshake.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state      <= IDLE;
            chain_reg  <= '0;
            cipher_reg <= '0;
            out_block  <= '0;
            out_valid  <= 1'b0;
            core_en    <= 1'b0;
            blk_cnt    <= '0;
`ifdef AES128_CBC_DEC_ECB_SEL_EN
            ecb_flag   <= 1'b0;
`endif
        end else begin
            core_en <= 1'b0;
            // Consumer handshake; a completion below on the same edge wins.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (iv_load) begin
                        chain_reg <= iv;
                        blk_cnt   <= '0;
                    end else if (accept) begin
                        cipher_reg <= in_block;
`ifdef AES128_CBC_DEC_ECB_SEL_EN
                        ecb_flag   <= ecb_mode;
`endif
                        state      <= START;
                    end
                end
                START: begin
                    if (core_ready) begin
                        core_en <= 1'b1;
                        state   <= WAIT_LOW;
                    end
                end
                // Wait for the core to acknowledge the start by dropping ready.
                WAIT_LOW: begin
                    if (!core_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_ready) begin
`ifdef AES128_CBC_DEC_ECB_SEL_EN
                        if (ecb_flag) begin
                            out_block <= core_plain;
                        end else begin
                            out_block <= core_plain ^ chain_reg;
                            chain_reg <= cipher_reg;
                        end
`else
                        out_block <= core_plain ^ chain_reg;
                        chain_reg <= cipher_reg;
`endif
                        out_valid <= 1'b1;
                        blk_cnt   <= blk_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes128_cbc_dec_ctrl.md
AES128_CBC_DEC_CTRL -- requirements
Module: aes128_cbc_dec_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock domain, synchronous active-low reset:
- clk_sys  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- iv_load  in  1  load iv into chain register.
- iv  in  128  initialisation vector.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  ciphertext block accepted when in_valid & in_ready.
- in_block  in  128  ciphertext block.
- out_valid  out  1  plaintext block available.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_block  out  128  plaintext block.
- core_en  out  1  one-cycle start pulse to the inverse cipher core (drives its decipher_en).
- core_cipher  out  128  ciphertext to the core.
- core_ready  in  1  core idle/done status (decipher_ready).
- core_plain  in  128  core result (plain_text).
- busy  out  1  high in any state other than IDLE.
- blk_cnt  out  16  blocks delivered since last iv_load.

Function
REQ-002 The FSM SHALL have states IDLE, START, WAIT_LOW, WAIT_DONE.
REQ-003 In IDLE, in_ready SHALL be 1 iff iv_load=0 and (out_valid=0 or out_ready=1).
REQ-004 On input handshake, in_block SHALL be captured into cipher_reg, and the FSM SHALL go to START.
REQ-005 In START, core_en SHALL pulse for exactly one cycle when core_ready=1, then go to WAIT_LOW; while core_ready=0, it SHALL hold START with core_en=0.
- core_cipher SHALL equal cipher_reg at all times.
REQ-006 WAIT_LOW SHALL go to WAIT_DONE when core_ready=0.
REQ-007 WAIT_DONE SHALL go to IDLE on the first cycle core_ready=1. On that edge:
- out_block <= core_plain ^ chain_reg.
- out_valid <= 1.
- chain_reg <= cipher_reg.
- blk_cnt increments by 1, wrapping 0xFFFF->0x0000.
REQ-008 With a core that asserts decipher_ready 11 cycles after decipher_en, out_valid SHALL rise exactly 14 cycles after the input handshake edge.
REQ-009 out_valid and out_block SHALL hold stable until out_ready=1; out_valid SHALL clear on the handshake cycle unless a new result is written on the same edge.
REQ-010 iv_load SHALL take effect only in IDLE:
- chain_reg <= iv and blk_cnt <= 0.
- It SHALL have priority over in_valid in the same cycle (in_ready=0).
- It SHALL be ignored in all other states.
REQ-011 A pending out_valid SHALL NOT block iv_load.
REQ-012 busy SHALL be 0 in IDLE and 1 otherwise.

Reset
REQ-013 When rst_n=0 at a clock edge, the block SHALL clear state regardless of FSM state:
- FSM = IDLE.
- out_valid, core_en, busy = 0.
- chain_reg, cipher_reg, out_block = 0.
- blk_cnt = 0.
REQ-014 After reset mid-operation, any core completion SHALL be ignored and no output produced.
REQ-015 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-016 With macro AES128_CBC_DEC_ECB_SEL_EN defined, the block SHALL add input port ecb_mode (1 bit), sampled at input handshake into a per-block flag. For a block accepted with ecb_mode=1:
- out_block = core_plain.
- chain_reg is unchanged.
- blk_cnt still increments.
REQ-017 Without AES128_CBC_DEC_ECB_SEL_EN, the ecb_mode port SHALL be absent and every block SHALL be CBC.

Verification (key 2b7e151628aed2a6abf7158809cf4f3c, FIPS-compliant core)
REQ-018 CBC block 1: iv_load with IV 000102030405060708090a0b0c0d0e0f, then in_block 7649abac8119b246cee98e9b12e9197d -> out_block 6bc1bee22e409f96e93d7e117393172a, blk_cnt=1.
REQ-019 CBC chaining: next in_block 5086cb9b507219ee95db113a917678b2 -> out_block ae2d8a571e03ac9c9eb76fac45af8e51, blk_cnt=2.
REQ-020 Backpressure: out_ready=0 for 20 cycles after out_valid -> out_block stable, in_ready=0, no second core_en; then out_ready=1 with in_valid=1 -> in_ready=1 same cycle.
REQ-021 Reset mid-op: rst_n=0 for 1 cycle during WAIT_DONE -> out_valid never asserts, blk_cnt=0, in_ready=1 the cycle after release.
REQ-022 Priority and latency:
- iv_load and in_valid together in IDLE -> chain_reg=iv, no handshake.
- Core held core_ready=0 in START -> core_en delayed until core_ready=1.
REQ-023 With AES128_CBC_DEC_ECB_SEL_EN, ecb_mode=1: in_block 3ad77bb40d7a3660a89ecaf32466ef97 -> out_block 6bc1bee22e409f96e93d7e117393172a, and the following CBC block still uses the prior chain_reg.
